// File: rtl/mean_div_ctrl.sv
// mean_div_ctrl: controller for the reciprocal-LUT averaging datapath.
// Accepts a burst of 1-4 unsigned samples, drives the reciprocal mux select,
// scales the sum by the returned Q16.16 reciprocal and presents the mean.
module mean_div_ctrl #(
    parameter int MAX_N = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic [2:0]  lut_sel,
    input  logic [31:0] recip,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_mean,
    output logic [2:0]  out_n
);

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_SEL,
        ST_MUL,
        ST_OUT
    } state_e;

    // Select value that makes the mux output zero.
    localparam logic [2:0] SEL_IDLE = 3'd4;
    localparam logic [2:0] N_MAX    = 3'(MAX_N);

    state_e      state_q,     state_d;
    logic [33:0] acc_q,       acc_d;
    logic [2:0]  n_q,         n_d;
    logic [31:0] recip_q,     recip_d;
    logic        in_ready_q,  in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_mean_q,  out_mean_d;
    logic [2:0]  out_n_q,     out_n_d;
    logic [2:0]  lut_sel_q,   lut_sel_d;

    logic        in_fire;
    logic [2:0]  n_inc;
    logic [65:0] product;
    logic [65:0] product_shr;

    assign in_fire     = in_valid && in_ready_q && (state_q == ST_ACCUM);
    assign n_inc       = n_q + 3'd1;
    // Full-width product; only bits [47:16] survive into the mean.
    assign product     = {32'd0, acc_q} * {34'd0, recip_q};
    assign product_shr = product >> 16;

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        // NOTE: every _d starts from its _q so no path through this block
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        acc_d       = acc_q;
        n_d         = n_q;
        recip_d     = recip_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_mean_d  = out_mean_q;
        out_n_d     = out_n_q;
        lut_sel_d   = lut_sel_q;

        unique case (state_q)
            ST_ACCUM: begin
                if (in_fire) begin
                    acc_d = acc_q + {2'b00, in_data};
                    n_d   = n_inc;
                    // The fourth sample closes the burst whatever in_last says.
                    if (in_last || (n_inc == N_MAX)) begin
                        state_d    = ST_SEL;
                        in_ready_d = 1'b0;
                        lut_sel_d  = N_MAX - n_inc;
                    end
                end
            end
            ST_SEL: begin
                // Mux is combinational: recip is settled by the end of this cycle.
                recip_d = recip;
                state_d = ST_MUL;
            end
            ST_MUL: begin
                out_mean_d  = 32'(product_shr);
                out_n_d     = n_q;
                out_valid_d = 1'b1;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    n_d         = '0;
                    lut_sel_d   = SEL_IDLE;
                    in_ready_d  = 1'b1;
                    state_d     = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // State and registered outputs, with synchronous reset to the idle burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            n_q         <= '0;
            recip_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_mean_q  <= '0;
            out_n_q     <= '0;
            lut_sel_q   <= SEL_IDLE;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            acc_q       <= acc_d;
            n_q         <= n_d;
            recip_q     <= recip_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_mean_q  <= out_mean_d;
            out_n_q     <= out_n_d;
            lut_sel_q   <= lut_sel_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_mean  = out_mean_q;
    assign out_n     = out_n_q;
    assign lut_sel   = lut_sel_q;

endmodule
